// File: rtl/data_island_packet_serializer.sv
// Serializes one HDMI data-island packet (24-bit header + four 56-bit subpackets)
// into 32 nine-bit words, appending BCH parity computed on the fly.
module data_island_packet_serializer #(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        packet_start,
    input  logic [23:0] header,
    input  logic [55:0] sub [3:0],
    output logic        packet_ready,
    output logic        packet_valid,
    output logic [4:0]  packet_index,
    output logic [8:0]  packet_data,
    output logic        packet_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            r_state;
    logic [4:0]        r_count;
    logic [23:0]       r_header;
    logic [3:0][55:0]  r_sub;
    logic [7:0]        r_ecc_h;
    logic [3:0][7:0]   r_ecc_s;

    logic              w_hbit;
    logic [3:0]        w_lo;
    logic [3:0]        w_hi;
    logic              w_last;
    logic              w_accept;

    function automatic logic [7:0] ecc_next(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    assign w_last       = (r_state == SEND) && (r_count == 5'd31);
    assign packet_ready = (r_state == IDLE) || (w_last && BACK_TO_BACK);
    assign w_accept     = packet_start && packet_ready;

    // Payload bits for the first 24/28 indices, then the held parity byte.
    always_comb begin
        w_hbit = (r_count < 5'd24) ? r_header[r_count] : r_ecc_h[r_count[2:0]];
        w_lo   = '0;
        w_hi   = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_count < 5'd28) begin
                w_lo[k] = r_sub[k][{r_count, 1'b0}];
                w_hi[k] = r_sub[k][{r_count, 1'b1}];
            end else begin
                w_lo[k] = r_ecc_s[k][{r_count[1:0], 1'b0}];
                w_hi[k] = r_ecc_s[k][{r_count[1:0], 1'b1}];
            end
        end
    end

    assign packet_valid = (r_state == SEND);
    assign packet_index = r_count;
    assign packet_done  = w_last;
    assign packet_data  = packet_valid ? {w_hi, w_lo, w_hbit} : 9'd0;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= 5'd0;
            r_header <= '0;
            r_sub    <= '0;
            r_ecc_h  <= '0;
            r_ecc_s  <= '0;
        end else if (w_accept) begin
            r_state  <= SEND;
            r_count  <= 5'd0;
            r_header <= header;
            for (int k = 0; k < 4; k++) begin
                r_sub[k] <= sub[k];
            end
            r_ecc_h  <= '0;
            r_ecc_s  <= '0;
        end else if (r_state == SEND) begin
            // Counter wraps 31 -> 0, leaving the idle index at 0.
            r_count <= r_count + 5'd1;
            if (r_count < 5'd24) begin
                r_ecc_h <= ecc_next(r_ecc_h, w_hbit);
            end
            for (int k = 0; k < 4; k++) begin
                if (r_count < 5'd28) begin
                    r_ecc_s[k] <= ecc_next(ecc_next(r_ecc_s[k], w_lo[k]), w_hi[k]);
                end
            end
            if (w_last) begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Bench for data_island_packet_serializer: two instances (back-to-back on/off)
// compared every cycle against a packet-level model built from bit streams.
module tb_data_island_packet_serializer;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        packet_start;
    logic [23:0] header;
    logic [55:0] sub [3:0];

    logic        o_ready [2];
    logic        o_valid [2];
    logic [4:0]  o_index [2];
    logic [8:0]  o_data  [2];
    logic        o_done  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_serializer #(.BACK_TO_BACK(1'b1)) u_b2b (
        .clk_pixel(clk_pixel), .reset(reset), .packet_start(packet_start),
        .header(header), .sub(sub),
        .packet_ready(o_ready[0]), .packet_valid(o_valid[0]), .packet_index(o_index[0]),
        .packet_data(o_data[0]), .packet_done(o_done[0])
    );

    data_island_packet_serializer #(.BACK_TO_BACK(1'b0)) u_gap (
        .clk_pixel(clk_pixel), .reset(reset), .packet_start(packet_start),
        .header(header), .sub(sub),
        .packet_ready(o_ready[1]), .packet_valid(o_valid[1]), .packet_index(o_index[1]),
        .packet_data(o_data[1]), .packet_done(o_done[1])
    );

    // Reference model: per instance, the 32 expected words of the packet in flight.
    logic [8:0] m_words [2][32];
    bit         m_busy  [2];
    int         m_idx   [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    // Each channel is a bit stream: payload followed by its parity byte.
    task automatic build(input int m);
        logic [7:0]  e;
        logic [31:0] hs;
        logic [63:0] ss [4];
        e = 8'h00;
        for (int i = 0; i < 24; i++) e = ecc_step(e, header[i]);
        hs = {e, header};
        for (int k = 0; k < 4; k++) begin
            e = 8'h00;
            for (int i = 0; i < 56; i++) e = ecc_step(e, sub[k][i]);
            ss[k] = {e, sub[k]};
        end
        for (int n = 0; n < 32; n++) begin
            m_words[m][n] = {ss[3][2*n+1], ss[2][2*n+1], ss[1][2*n+1], ss[0][2*n+1],
                             ss[3][2*n],   ss[2][2*n],   ss[1][2*n],   ss[0][2*n], hs[n]};
        end
    endtask

    function automatic bit m_ready(input int m);
        return !m_busy[m] || (m_idx[m] == 31 && m == 0);
    endfunction

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("valid%0d", m), 32'(o_valid[m]), 32'(m_busy[m]));
            check_val($sformatf("index%0d", m), 32'(o_index[m]), m_busy[m] ? 32'(m_idx[m]) : 32'd0);
            check_val($sformatf("data%0d", m), 32'(o_data[m]), m_busy[m] ? 32'(m_words[m][m_idx[m]]) : 32'd0);
            check_val($sformatf("done%0d", m), 32'(o_done[m]), 32'(m_busy[m] && m_idx[m] == 31));
            check_val($sformatf("ready%0d", m), 32'(o_ready[m]), 32'(m_ready(m)));
        end
    endtask

    // Advance the model with the inputs the coming edge will sample, then check.
    task automatic cycle();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_busy[m] = 1'b0;
                m_idx[m]  = 0;
            end else if (packet_start && m_ready(m)) begin
                build(m);
                m_busy[m] = 1'b1;
                m_idx[m]  = 0;
            end else if (m_busy[m]) begin
                if (m_idx[m] == 31) begin
                    m_busy[m] = 1'b0;
                    m_idx[m]  = 0;
                end else begin
                    m_idx[m]++;
                end
            end
        end
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        check_outputs();
    endtask

    task automatic randomize_inputs();
        header = 24'($urandom);
        for (int k = 0; k < 4; k++) sub[k] = 56'({$urandom, $urandom});
    endtask

    task automatic pulse_start(input int idle_cycles);
        packet_start = 1'b1;
        cycle();
        packet_start = 1'b0;
        randomize_inputs();
        repeat (idle_cycles) cycle();
    endtask

    initial begin
        m_busy = '{1'b0, 1'b0};
        m_idx  = '{0, 0};
        reset = 1'b1;
        packet_start = 1'b0;
        header = '0;
        for (int k = 0; k < 4; k++) sub[k] = '0;
        @(negedge clk_pixel);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // All-zero packet, then the AVI InfoFrame header.
        pulse_start(33);
        header = 24'h0D0282;
        for (int k = 0; k < 4; k++) sub[k] = '0;
        pulse_start(33);

        // Single-bit patterns on header bit 0 and subpacket 2 bit 55.
        header = 24'h000001;
        for (int k = 0; k < 4; k++) sub[k] = '0;
        sub[2] = 56'd1 << 55;
        pulse_start(33);

        // Start at index 31: accepted only by the back-to-back instance.
        randomize_inputs();
        pulse_start(31);
        randomize_inputs();
        pulse_start(34);

        // Start while busy at index 10 is ignored.
        randomize_inputs();
        pulse_start(10);
        randomize_inputs();
        pulse_start(25);

        // Reset at index 15, then a clean packet.
        randomize_inputs();
        pulse_start(15);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        randomize_inputs();
        pulse_start(33);

        // Random traffic with occasional resets.
        repeat (800) begin
            randomize_inputs();
            packet_start = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 249) == 0);
            cycle();
        end
        reset = 1'b0;
        packet_start = 1'b0;
        repeat (34) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
